uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter and its baud generator between NUM_REQ byte sources.
// Optional BUSY watchdog (err pulse after TIMEOUT_CYCLES) is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter logic [1:0]  DEFAULT_SEL    = 2'b01,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [1:0]           sel,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [2:0]           owner,
  output logic                 arb_busy,
  output logic                 err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, START, BUSY} state_t;

  state_t                  state;
  logic [IW-1:0]           ptr;
  logic [SW-1:0]           scnt;
  logic [NUM_REQ-1:0][7:0] dat_a;
  logic [NUM_REQ-1:0][1:0] sel_a;

  assign dat_a = req_data;
  assign sel_a = req_sel;

  // Rotate so bit 0 is the requester just after ptr; lowest set bit wins.
  logic [2*NUM_REQ-1:0] rot2;
  logic [IW:0]          sum;
  logic [IW-1:0]        win;

  always_comb begin
    rot2 = {req, req} >> ({1'b0, ptr} + (IW+1)'(1));
    sum  = '0;
    win  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot2[j]) begin
        sum = {1'b0, ptr} + (IW+1)'(j) + (IW+1)'(1);
        if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
        win = sum[IW-1:0];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      sel      <= DEFAULT_SEL;
      gnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      owner    <= '0;
      arb_busy <= 1'b0;
      ptr      <= IW'(NUM_REQ - 1);
      scnt     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err      <= 1'b0;
      tcnt     <= '0;
`endif
    end else begin
      gnt      <= '0;
      tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= NUM_REQ'(1) << win;
            tx_data  <= dat_a[win];
            owner    <= 3'(win);
            ptr      <= win;
            arb_busy <= 1'b1;
            // The baud generator may only be retuned here, while the transmitter is idle.
            if (sel_a[win] == sel) begin
              state <= START;
            end else begin
              sel   <= sel_a[win];
              scnt  <= SW'(SETTLE_CYCLES);
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          scnt <= scnt - SW'(1);
          if (scnt <= SW'(1)) state <= START;
        end
        START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            tcnt     <= '0;
`endif
          end
        end
        BUSY: begin
          if (tx_done) begin
            state    <= IDLE;
            arb_busy <= 1'b0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err      <= 1'b1;
            state    <= IDLE;
            arb_busy <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, SETTLE_CYCLES=16).
// The timeout scenario runs when UART_ARB_TIMEOUT_EN is defined; otherwise BUSY must hold.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int SC  = 16;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_data;
  logic [2*NR-1:0] req_sel;
  logic [NR-1:0] gnt;
  logic [1:0]    sel;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          tx_done;
  logic [2:0]    owner;
  logic          arb_busy;
  logic          err;

  int npass = 0;
  int nchk  = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .SETTLE_CYCLES(SC), .DEFAULT_SEL(2'b01), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_sel(req_sel),
    .gnt(gnt), .sel(sel), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_done(tx_done), .owner(owner), .arb_busy(arb_busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] s, input logic [7:0] d);
    req_sel[2*i +: 2]  = s;
    req_data[8*i +: 8] = d;
  endtask

  task automatic wait_gnt();
    int n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    chk("gnt_wait", 32'(gnt != '0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int early;
    int errs;
    int busy_low;
    int exp_rr[5];
    exp_rr = '{0, 1, 3, 0, 1};

    // reset held with all requests pending
    reset = 1'b0; req = 4'b1111; req_sel = 8'b01010101; req_data = 32'h44332211;
    tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) tick();
    chk("rst_gnt",   32'(gnt),      32'(0));
    chk("rst_start", 32'(tx_start), 32'(0));
    chk("rst_sel",   32'(sel),      32'(2'b01));
    chk("rst_busy",  32'(arb_busy), 32'(0));
    chk("rst_owner", 32'(owner),    32'(0));
    chk("rst_err",   32'(err),      32'(0));
    chk("rst_txd",   32'(tx_data),  32'(0));
    reset = 1'b1;
    tick();
    chk("first_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    tick();
    chk("first_start", 32'(tx_start), 32'(1));
    chk("first_data",  32'(tx_data),  32'(8'h11));
    tick();
    done_pulse();
    chk("first_idle", 32'(arb_busy), 32'(0));

    // same-sel fast path
    set_req(2, 2'b01, 8'hA5);
    req = 4'b0100;
    tick();
    chk("fast_gnt",   32'(gnt),   32'(4'b0100));
    chk("fast_sel",   32'(sel),   32'(2'b01));
    chk("fast_owner", 32'(owner), 32'(2));
    req = '0;
    tick();
    chk("fast_start", 32'(tx_start), 32'(1));
    chk("fast_data",  32'(tx_data),  32'(8'hA5));
    chk("fast_sel2",  32'(sel),      32'(2'b01));
    tick();
    chk("fast_pulse", 32'(tx_start), 32'(0));
    done_pulse();
    chk("fast_idle", 32'(arb_busy), 32'(0));

    // sel change: tx_start exactly 18 cycles after req
    set_req(1, 2'b00, 8'h5A);
    req = 4'b0010;
    tick();
    chk("chg_gnt",  32'(gnt),      32'(4'b0010));
    chk("chg_sel",  32'(sel),      32'(2'b00));
    chk("chg_busy", 32'(arb_busy), 32'(1));
    req = '0;
    early = 0;
    repeat (SC) begin
      tick();
      if (tx_start) early++;
    end
    chk("chg_nostart", 32'(early), 32'(0));
    tick();
    chk("chg_start", 32'(tx_start), 32'(1));
    chk("chg_data",  32'(tx_data),  32'(8'h5A));
    chk("chg_sel2",  32'(sel),      32'(2'b00));
    tick();
    done_pulse();

    // round-robin with req held at 4'b1011 from a fresh reset
    reset = 1'b0; req_sel = 8'b01010101; req_data = 32'h44332211; req = 4'b1011;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt();
      chk($sformatf("rr_gnt%0d", i),   32'(gnt),   32'(1) << exp_rr[i]);
      chk($sformatf("rr_owner%0d", i), 32'(owner), 32'(exp_rr[i]));
      if (i == 4) req = '0;
      tick();
      chk($sformatf("rr_start%0d", i), 32'(tx_start), 32'(1));
      chk($sformatf("rr_data%0d", i),  32'(tx_data),  32'(8'h11) * 32'(exp_rr[i] + 1));
      repeat (4) tick();
      done_pulse();
    end
    chk("rr_idle", 32'(arb_busy), 32'(0));

    // busy stall plus a stray done during SETTLE
    set_req(3, 2'b10, 8'h3C);
    req = 4'b1000;
    tx_busy = 1'b1;
    tick();
    chk("stall_gnt", 32'(gnt), 32'(4'b1000));
    chk("stall_sel", 32'(sel), 32'(2'b10));
    req = '0;
    early = 0;
    repeat (5) begin
      tick();
      if (tx_start) early++;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("stray_busy", 32'(arb_busy), 32'(1));
    repeat (12) begin
      tick();
      if (tx_start) early++;
    end
    chk("stall_nostart", 32'(early),    32'(0));
    chk("stall_busy",    32'(arb_busy), 32'(1));
    tx_busy = 1'b0;
    tick();
    chk("stall_start", 32'(tx_start), 32'(1));
    chk("stall_data",  32'(tx_data),  32'(8'h3C));
    tick();
    reset = 1'b0;
    tick();
    chk("rb_busy",  32'(arb_busy), 32'(0));
    chk("rb_sel",   32'(sel),      32'(2'b01));
    chk("rb_start", 32'(tx_start), 32'(0));
    reset = 1'b1;

    // BUSY with no tx_done: watchdog if built, otherwise wait forever
    set_req(0, 2'b01, 8'h77);
    set_req(1, 2'b01, 8'h88);
    req = 4'b0001;
    wait_gnt();
    chk("tmo_gnt", 32'(gnt), 32'(4'b0001));
    req = 4'b0010;
    tick();
    chk("tmo_start", 32'(tx_start), 32'(1));
    errs = 0;
    busy_low = 0;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (TMO - 1) begin
      tick();
      if (err) errs++;
      if (!arb_busy) busy_low++;
    end
    chk("tmo_early_err", 32'(errs),     32'(0));
    chk("tmo_early_idle", 32'(busy_low), 32'(0));
    tick();
    chk("tmo_err",  32'(err),      32'(1));
    chk("tmo_idle", 32'(arb_busy), 32'(0));
    chk("tmo_sel",  32'(sel),      32'(2'b01));
    tick();
    chk("tmo_err_pulse", 32'(err), 32'(0));
    chk("tmo_regnt",     32'(gnt), 32'(4'b0010));
    req = '0;
`else
    repeat (TMO + 20) begin
      tick();
      if (err) errs++;
      if (!arb_busy) busy_low++;
    end
    chk("hold_err",  32'(errs),     32'(0));
    chk("hold_busy", 32'(busy_low), 32'(0));
    chk("hold_nognt", 32'(gnt),     32'(0));
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
